aes_round_sequencer: RTL and testbench
======================================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; legal values are 10, 12 and 14.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  synchronous, active-low reset, sampled on i_clk rising edge.
REQ-004 SHALL have port i_valid  input  1  plaintext block offered.
REQ-005 SHALL have port o_ready  output  1  sequencer idle, will accept i_block.
REQ-006 SHALL have port i_block  input  128  plaintext, byte 0 at [127:120], column-major, one 32-bit column per word.
REQ-007 SHALL have port o_key_req  output  1  round key requested.
REQ-008 SHALL have port o_key_idx  output  4  index of the requested round key, 0..NR.
REQ-009 SHALL have port i_key_valid  input  1  i_round_key is valid for o_key_idx.
REQ-010 SHALL have port i_round_key  input  128  round key, same byte order as i_block.
REQ-011 SHALL have port i_abort  input  1  cancel the block in flight.
REQ-012 SHALL have port o_valid  output  1  ciphertext available.
REQ-013 SHALL have port i_out_ready  input  1  consumer accepts o_block.
REQ-014 SHALL have port o_block  output  128  ciphertext, same byte order as i_block.
REQ-015 SHALL have port o_busy  output  1  high in ROUND state.

Function
REQ-016 SHALL implement FSM states IDLE, ROUND, DONE, plus a 128-bit state register and a 4-bit round counter rnd.
REQ-017 IDLE: o_ready=1; on i_valid=1, capture i_block into state, set rnd=0, go to ROUND.
REQ-018 ROUND: o_key_req=1, o_key_idx=rnd; when i_key_valid=0, hold state and rnd (stall, no limit).
REQ-019 ROUND with i_key_valid=1 and rnd=0: state <= state XOR i_round_key; rnd <= 1.
REQ-020 ROUND with i_key_valid=1 and 1<=rnd<=NR-1: state <= MixColumns(ShiftRows(SubBytes(state))) XOR i_round_key; rnd <= rnd+1.
REQ-021 ROUND with i_key_valid=1 and rnd=NR: state <= ShiftRows(SubBytes(state)) XOR i_round_key, with no MixColumns; go to DONE.
REQ-022 MixColumns SHALL use GF(2^8) with polynomial 0x11B, matrix rows {02,03,01,01}, applied independently to each 32-bit column.
REQ-023 DONE: o_valid=1, o_block=state; on i_out_ready=1, go to IDLE, with o_ready=1 in the following cycle.
REQ-024 o_block SHALL be held stable while o_valid=1 and i_out_ready=0.
REQ-025 Latency with i_key_valid always 1 and no backpressure: accept at edge T, o_valid high from edge T+NR+1, total NR+1 key cycles.
REQ-026 i_abort=1 in ROUND: go to IDLE at the next edge, no o_valid, key request dropped; i_abort overrides a simultaneous i_key_valid.
REQ-027 i_abort SHALL be ignored in IDLE and DONE.
REQ-028 o_key_req, o_busy, o_valid SHALL be 0 outside their states; o_key_idx=0 outside ROUND.
REQ-029 i_valid in ROUND or DONE SHALL be ignored (o_ready=0), with no capture.
REQ-030 All outputs SHALL be driven from registers or decoded from FSM state only, with no combinational path from i_key_valid, i_valid or i_out_ready to any output.

Reset
REQ-031 i_rst_n=0 at an edge SHALL force IDLE, rnd=0, state=0, from any state including mid-ROUND and DONE.
REQ-032 Outputs after reset: o_ready=1, o_valid=0, o_key_req=0, o_key_idx=0, o_busy=0, o_block=0.
REQ-033 A block in flight at reset SHALL be discarded, with no o_valid for it.

Verification
REQ-034 FIPS-197 C.1 (NR=10): key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, bench key model always valid -> o_block=69c4e0d86a7b0430d8cdb78070b4c55a, o_valid at accept+11.
REQ-035 Same vector with i_key_valid randomly low about 50% of cycles -> identical ciphertext; o_key_idx visits 0..10 in order, each held until its key is valid.
REQ-036 Backpressure: i_out_ready=0 for 20 cycles after o_valid -> o_block stable, o_ready=0; i_out_ready=1 -> o_ready=1 one cycle later; a second block with i_valid held high is accepted then.
REQ-037 i_abort at rnd=5 -> IDLE next edge, o_valid never asserts; the next block still yields the correct ciphertext.
REQ-038 i_rst_n=0 for one edge at rnd=7 and again in DONE -> REQ-032 values on the next cycle; no stale o_valid.
REQ-039 NR=14, FIPS-197 C.3: plaintext 00112233445566778899aabbccddeeff, key 000102...1f -> 8ea2b7ca516745bfeafc49904b496089, o_valid at accept+15.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES encryption round sequencer: accepts one 128-bit block, fetches NR+1
// round keys one at a time from an external key source, applies the AES
// rounds one per accepted key, then presents the ciphertext until taken.
//
// Handshakes (all strict valid/ready):
//   input block : transfer on a rising edge where i_valid && o_ready.
//   round key   : transfer on a rising edge where o_key_req && i_key_valid;
//                 o_key_idx names the key wanted and holds until it arrives.
//   output block: transfer on a rising edge where o_valid && i_out_ready;
//                 o_block is stable while o_valid is high and not taken.
// Every output is a register or a decode of the FSM state register, so no
// input reaches an output combinationally. NR must be 10, 12 or 14.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_block,
    output logic         o_key_req,
    output logic [3:0]   o_key_idx,
    input  logic         i_key_valid,
    input  logic [127:0] i_round_key,
    input  logic         i_abort,
    output logic         o_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_block,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    // AES forward S-box, index 0 is the leftmost entry.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block lives at [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Each column multiplied by the circulant matrix {02,03,01,01}.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] sr_data;
    logic [127:0] mc_data;

    assign sr_data = shift_rows(sub_bytes(data_q));
    assign mc_data = mix_columns(sr_data);

    // State, block and round counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fsm_q  <= IDLE;
            data_q <= '0;
            rnd_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            rnd_q  <= rnd_d;
        end
    end

    // Next-state logic: capture, one round per accepted key, abort, hand-off.
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        rnd_d  = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    data_d = i_block;
                    rnd_d  = 4'd0;
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                if (i_abort) begin
                    // Abort wins over a key arriving on the same edge.
                    rnd_d = 4'd0;
                    fsm_d = IDLE;
                end else if (i_key_valid) begin
                    if (rnd_q == 4'd0) begin
                        data_d = data_q ^ i_round_key;
                        rnd_d  = 4'd1;
                    end else if (rnd_q == LAST_RND) begin
                        data_d = sr_data ^ i_round_key;
                        rnd_d  = 4'd0;
                        fsm_d  = DONE;
                    end else begin
                        data_d = mc_data ^ i_round_key;
                        rnd_d  = rnd_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign o_ready   = (fsm_q == IDLE);
    assign o_key_req = (fsm_q == ROUND);
    assign o_busy    = (fsm_q == ROUND);
    assign o_valid   = (fsm_q == DONE);
    assign o_key_idx = (fsm_q == ROUND) ? rnd_q : 4'd0;
    assign o_block   = data_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: an NR=10 instance covers the main
// scenarios, an NR=14 instance covers AES-256. Round keys come from a
// key-expansion model built on an arithmetic S-box; ciphertexts are the
// published FIPS-197 values.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // NR=10 instance signals
    logic         a_rst_n = 1'b0;
    logic         a_valid = 1'b0;
    logic [127:0] a_block = '0;
    logic         a_key_valid = 1'b0;
    logic [127:0] a_round_key = '0;
    logic         a_abort = 1'b0;
    logic         a_out_ready = 1'b1;
    logic         a_o_ready, a_o_key_req, a_o_valid, a_o_busy;
    logic [3:0]   a_o_key_idx;
    logic [127:0] a_o_block;

    // NR=14 instance signals
    logic         b_rst_n = 1'b0;
    logic         b_valid = 1'b0;
    logic [127:0] b_block = '0;
    logic         b_key_valid = 1'b0;
    logic [127:0] b_round_key = '0;
    logic         b_abort = 1'b0;
    logic         b_out_ready = 1'b1;
    logic         b_o_ready, b_o_key_req, b_o_valid, b_o_busy;
    logic [3:0]   b_o_key_idx;
    logic [127:0] b_o_block;

    aes_round_sequencer #(.NR(10)) dut10 (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_valid(a_valid), .o_ready(a_o_ready),
        .i_block(a_block), .o_key_req(a_o_key_req), .o_key_idx(a_o_key_idx),
        .i_key_valid(a_key_valid), .i_round_key(a_round_key), .i_abort(a_abort),
        .o_valid(a_o_valid), .i_out_ready(a_out_ready), .o_block(a_o_block),
        .o_busy(a_o_busy)
    );

    aes_round_sequencer #(.NR(14)) dut14 (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_block(b_block), .o_key_req(b_o_key_req), .o_key_idx(b_o_key_idx),
        .i_key_valid(b_key_valid), .i_round_key(b_round_key), .i_abort(b_abort),
        .o_valid(b_o_valid), .i_out_ready(b_out_ready), .o_block(b_o_block),
        .o_busy(b_o_busy)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];
    logic [127:0] rk[0:14];
    int           key_mode = 0;     // 0: key always valid, 1: valid ~50%
    int           idx_log[$];       // o_key_idx values at each key transfer

    // ---------------- key model ----------------
    function automatic logic [7:0] m_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = m_xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: inverse (x^254) then the affine map.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e = 8'd254;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = m_gmul(r, base);
            base = m_gmul(base, base);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] m_sub_word(input logic [31:0] w);
        return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
    endfunction

    // Fill rk[0..nr] from a key of nk words (left-aligned in 256 bits).
    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = m_sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = m_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = m_sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key source for both instances, driven on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            a_key_valid = a_o_key_req && (key_mode == 0 || $urandom_range(0, 1) == 1);
            a_round_key = (a_key_valid && a_o_key_idx <= 4'd14) ? rk[a_o_key_idx]
                        : {$urandom, $urandom, $urandom, $urandom};
            if (a_key_valid) idx_log.push_back(int'(a_o_key_idx));
            b_key_valid = b_o_key_req;
            b_round_key = (b_key_valid && b_o_key_idx <= 4'd14) ? rk[b_o_key_idx]
                        : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [127:0] pt, input logic [127:0] ct);
        a_valid = 1'b1;
        a_block = pt;
        tick();
        a_valid = 1'b0;
        exp_q.push_back(ct);
    endtask

    task automatic a_wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!a_o_valid && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0 || a_o_key_req !== 1'b0 ||
            a_o_key_idx !== 4'd0 || a_o_busy !== 1'b0 || a_o_block !== 128'h0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%0b valid=%0b key_req=%0b idx=%0d busy=%0b block=%h want 1 0 0 0 0 0",
                     a_o_ready, a_o_valid, a_o_key_req, a_o_key_idx, a_o_busy, a_o_block);
        end
        checks++;
        if (b_o_ready !== 1'b1 || b_o_valid !== 1'b0 || b_o_busy !== 1'b0 || b_o_block !== 128'h0) begin
            failures++;
            $display("FAIL reset_outputs_nr14 got ready=%0b valid=%0b busy=%0b block=%h want 1 0 0 0",
                     b_o_ready, b_o_valid, b_o_busy, b_o_block);
        end
    endtask

    task automatic test_fips_c1();
        int cycles;
        logic [127:0] exp;
        key_mode = 0;
        expand_key({K1, 128'h0}, 4, 10);
        a_send(PT1, CT1);
        checks++;
        if (a_o_busy !== 1'b1 || a_o_key_req !== 1'b1 || a_o_ready !== 1'b0 || a_o_key_idx !== 4'd0) begin
            failures++;
            $display("FAIL c1_round_entry got busy=%0b key_req=%0b ready=%0b idx=%0d want 1 1 0 0",
                     a_o_busy, a_o_key_req, a_o_ready, a_o_key_idx);
        end
        a_wait_valid(40, cycles);
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || cycles != 11) begin
            failures++;
            $display("FAIL c1_latency got valid=%0b cycles=%0d want valid=1 cycles=11", a_o_valid, cycles);
        end
        checks++;
        if (a_o_block !== exp) begin
            failures++;
            $display("FAIL c1_cipher got=%h want=%h", a_o_block, exp);
        end
        tick();
        checks++;
        if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
            failures++;
            $display("FAIL c1_release got ready=%0b valid=%0b want 1 0", a_o_ready, a_o_valid);
        end
    endtask

    task automatic test_random_stall();
        int cycles;
        int bad;
        logic [127:0] exp;
        key_mode = 1;
        expand_key({K1, 128'h0}, 4, 10);
        idx_log.delete();
        a_send(PT1, CT1);
        a_wait_valid(400, cycles);
        key_mode = 0;
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || a_o_block !== exp) begin
            failures++;
            $display("FAIL stall_cipher got valid=%0b block=%h want valid=1 block=%h", a_o_valid, a_o_block, exp);
        end
        bad = (idx_log.size() != 11) ? 1 : 0;
        for (int i = 0; i < idx_log.size() && i < 11; i++) begin
            if (idx_log[i] != i) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_key_order got count=%0d first_bad_log=%p want indices 0..10", idx_log.size(), idx_log);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cycles;
        int bad = 0;
        logic [127:0] exp;
        logic [127:0] hold;
        expand_key({K1, 128'h0}, 4, 10);
        a_out_ready = 1'b0;
        a_send(PT1, CT1);
        a_wait_valid(40, cycles);
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || a_o_block !== exp) begin
            failures++;
            $display("FAIL bp_first_cipher got valid=%0b block=%h want valid=1 block=%h", a_o_valid, a_o_block, exp);
        end
        hold = a_o_block;
        expand_key({KB, 128'h0}, 4, 10);
        a_valid = 1'b1;
        a_block = PTB;
        a_abort = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_o_block !== hold || a_o_valid !== 1'b1 || a_o_ready !== 1'b0) bad++;
        end
        a_abort = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ready=%0b valid=%0b want 1 0", a_o_ready, a_o_valid);
        end
        tick();
        exp_q.push_back(CTB);
        a_valid = 1'b0;
        checks++;
        if (a_o_busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_accept got busy=%0b want 1", a_o_busy);
        end
        a_wait_valid(40, cycles);
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || cycles != 11 || a_o_block !== exp) begin
            failures++;
            $display("FAIL bp_second_cipher got valid=%0b cycles=%0d block=%h want 1 11 %h",
                     a_o_valid, cycles, a_o_block, exp);
        end
        tick();
    endtask

    task automatic test_ignore_valid();
        int cycles;
        int bad = 0;
        logic [127:0] exp;
        expand_key({K1, 128'h0}, 4, 10);
        a_send(PT1, CT1);
        a_valid = 1'b1;
        a_block = PTB;
        for (int i = 0; i < 4; i++) begin
            if (a_o_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_ready got %0d cycles ready=1 want 0", bad);
        end
        a_wait_valid(40, cycles);
        a_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || a_o_block !== exp) begin
            failures++;
            $display("FAIL busy_no_capture got valid=%0b block=%h want valid=1 block=%h", a_o_valid, a_o_block, exp);
        end
        tick();
        tick();
        checks++;
        if (a_o_ready !== 1'b1 || a_o_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle_after got ready=%0b busy=%0b want 1 0", a_o_ready, a_o_busy);
        end
    endtask

    task automatic test_abort();
        int cycles;
        int n = 0;
        int seen = 0;
        logic [127:0] exp;
        expand_key({K1, 128'h0}, 4, 10);
        a_send(PT1, CT1);
        while (a_o_key_idx != 4'd5 && n < 30) begin
            tick();
            n++;
        end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (a_o_ready !== 1'b1 || a_o_key_req !== 1'b0 || a_o_busy !== 1'b0 || a_o_key_idx !== 4'd0) begin
            failures++;
            $display("FAIL abort_idle got ready=%0b key_req=%0b busy=%0b idx=%0d want 1 0 0 0",
                     a_o_ready, a_o_key_req, a_o_busy, a_o_key_idx);
        end
        for (int i = 0; i < 20; i++) begin
            if (a_o_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_valid got %0d valid cycles want 0", seen);
        end
        expand_key({KB, 128'h0}, 4, 10);
        a_send(PTB, CTB);
        a_wait_valid(40, cycles);
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || a_o_block !== exp) begin
            failures++;
            $display("FAIL abort_next_cipher got valid=%0b block=%h want valid=1 block=%h", a_o_valid, a_o_block, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cycles;
        int n = 0;
        int seen = 0;
        logic [127:0] exp;
        expand_key({K1, 128'h0}, 4, 10);
        a_send(PT1, CT1);
        while (a_o_key_idx != 4'd7 && n < 30) begin
            tick();
            n++;
        end
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        void'(exp_q.pop_back());
        checks++;
        if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0 || a_o_key_req !== 1'b0 ||
            a_o_key_idx !== 4'd0 || a_o_busy !== 1'b0 || a_o_block !== 128'h0) begin
            failures++;
            $display("FAIL rst_round got ready=%0b valid=%0b key_req=%0b idx=%0d busy=%0b block=%h want 1 0 0 0 0 0",
                     a_o_ready, a_o_valid, a_o_key_req, a_o_key_idx, a_o_busy, a_o_block);
        end
        for (int i = 0; i < 15; i++) begin
            if (a_o_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_round_no_valid got %0d valid cycles want 0", seen);
        end
        a_out_ready = 1'b0;
        a_send(PT1, CT1);
        a_wait_valid(40, cycles);
        exp = exp_q.pop_front();
        checks++;
        if (a_o_valid !== 1'b1 || a_o_block !== exp) begin
            failures++;
            $display("FAIL rst_pre_done got valid=%0b block=%h want valid=1 block=%h", a_o_valid, a_o_block, exp);
        end
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        a_out_ready = 1'b1;
        checks++;
        if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0 || a_o_key_req !== 1'b0 ||
            a_o_key_idx !== 4'd0 || a_o_busy !== 1'b0 || a_o_block !== 128'h0) begin
            failures++;
            $display("FAIL rst_done got ready=%0b valid=%0b key_req=%0b idx=%0d busy=%0b block=%h want 1 0 0 0 0 0",
                     a_o_ready, a_o_valid, a_o_key_req, a_o_key_idx, a_o_busy, a_o_block);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_o_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_done_stale_valid got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_nr14();
        int cycles = 0;
        logic [127:0] exp;
        expand_key(K256, 8, 14);
        b_valid = 1'b1;
        b_block = PT1;
        tick();
        b_valid = 1'b0;
        exp_q.push_back(CT14);
        while (!b_o_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (b_o_valid !== 1'b1 || cycles != 15) begin
            failures++;
            $display("FAIL nr14_latency got valid=%0b cycles=%0d want valid=1 cycles=15", b_o_valid, cycles);
        end
        checks++;
        if (b_o_block !== exp) begin
            failures++;
            $display("FAIL nr14_cipher got=%h want=%h", b_o_block, exp);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        tick();
        tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        test_reset();
        test_fips_c1();
        test_random_stall();
        test_backpressure();
        test_ignore_valid();
        test_abort();
        test_reset_mid();
        test_nr14();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
